red_pitaya_rst_seq: RTL and testbench

Synthesizable, parametrised power-on reset and tristate-release sequencer. It replaces a single fixed-width global reset/tristate pulse with several things: a lock-qualified start, a common hold period, staggered per-channel reset release with runtime-programmable delays, and a delayed tristate release. It also restarts automatically on PLL lock loss or software request. It sits next to the clock/PLL block and drives the reset inputs of downstream subsystems such as the ADC/DAC paths, the housekeeping logic and the bus bridge.

---
 rtl/red_pitaya_rst_seq_if.sv | 17 +
 rtl/red_pitaya_rst_seq.sv | 109 ++++++++++
 tb/tb_red_pitaya_rst_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/red_pitaya_rst_seq_if.sv
// Control and status bundle between the reset sequencer and its environment.
// The sequencer takes the slave side; the lock/software/delay source takes the master side.
interface red_pitaya_rst_seq_if #(
  parameter int NCH = 4,
  parameter int CW  = 20
);
  logic              lock_i;
  logic              swrst_i;
  logic [NCH*CW-1:0] dly_i;
  logic [NCH-1:0]    rst_o;
  logic              gts_o;
  logic              done_o;
  logic [2:0]        state_o;

  modport master (output lock_i, swrst_i, dly_i, input rst_o, gts_o, done_o, state_o);
  modport slave  (input lock_i, swrst_i, dly_i, output rst_o, gts_o, done_o, state_o);
endinterface

// File: rtl/red_pitaya_rst_seq.sv
// Power-on reset / tristate sequencer: lock-qualified start, common hold,
// staggered per-channel release with runtime delays, delayed tristate release.
module red_pitaya_rst_seq #(
  parameter int NCH       = 4,
  parameter int CW        = 20,
  parameter int ROC_CYC   = 100,
  parameter int TOC_CYC   = 0,
  parameter int LOCK_FILT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  red_pitaya_rst_seq_if.slave  bus
);
  localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] S_WAIT_LOCK = 3'd0;
  localparam logic [2:0] S_HOLD      = 3'd1;
  localparam logic [2:0] S_STAGGER   = 3'd2;
  localparam logic [2:0] S_TRIS      = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]     state;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  filt;
  logic [KW-1:0]  k;
  logic [NCH-1:0] rst_q;
  logic           gts_q;
  logic           done_q;
  logic [CW-1:0]  dly [NCH];
  logic [CW-1:0]  dly_k;
  logic           restart;

  for (genvar g = 0; g < NCH; g++) begin : g_dly
    assign dly[g] = bus.dly_i[g*CW +: CW];
  end

  assign dly_k = dly[k];
  // Once the sequence has left WAIT_LOCK, losing lock or a software request starts over.
  assign restart = (state != S_WAIT_LOCK) && (!bus.lock_i || bus.swrst_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || restart) begin
      state  <= S_WAIT_LOCK;
      cnt    <= '0;
      filt   <= '0;
      k      <= '0;
      rst_q  <= '1;
      gts_q  <= 1'b1;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_WAIT_LOCK: begin
          if (bus.swrst_i || !bus.lock_i) begin
            filt <= '0;
          end else if (filt == CW'(LOCK_FILT - 1)) begin
            state <= S_HOLD;
            cnt   <= '0;
            filt  <= '0;
          end else begin
            filt <= filt + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == CW'(ROC_CYC - 1)) begin
            state <= S_STAGGER;
            cnt   <= '0;
            k     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STAGGER: begin
          // >= so a delay lowered mid-count releases on the next edge instead of wrapping
          if (cnt >= dly_k) begin
            rst_q[k] <= 1'b0;
            cnt      <= '0;
            if (k != KW'(NCH - 1)) begin
              k <= k + 1'b1;
            end else if (TOC_CYC == 0) begin
              gts_q  <= 1'b0;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              state <= S_TRIS;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_TRIS: begin
          if (cnt == CW'(TOC_CYC - 1)) begin
            gts_q  <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: state <= S_DONE;
        default: state <= S_WAIT_LOCK;
      endcase
    end
  end

  assign bus.rst_o   = rst_q;
  assign bus.gts_o   = gts_q;
  assign bus.done_o  = done_q;
  assign bus.state_o = state;
endmodule

// File: tb/tb_red_pitaya_rst_seq.sv
// Bench for red_pitaya_rst_seq: two instances (TOC 0 and 5) share stimulus and are
// checked each cycle against release edges computed from the timing rules.
module tb_red_pitaya_rst_seq;
  localparam int NCH   = 4;
  localparam int CW    = 20;
  localparam int ROC   = 100;
  localparam int LF    = 16;
  localparam int TOC_A = 0;
  localparam int TOC_B = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              lock;
  logic              swrst;
  logic [NCH*CW-1:0] dly;

  int n_assert = 0;
  int n_fail   = 0;
  int dv   [NCH];
  int fall [NCH];
  int h_edge, s_edge;

  always #5 clk = ~clk;

  red_pitaya_rst_seq_if #(.NCH(NCH), .CW(CW)) ifa ();
  red_pitaya_rst_seq_if #(.NCH(NCH), .CW(CW)) ifb ();

  assign ifa.lock_i  = lock;
  assign ifa.swrst_i = swrst;
  assign ifa.dly_i   = dly;
  assign ifb.lock_i  = lock;
  assign ifb.swrst_i = swrst;
  assign ifb.dly_i   = dly;

  red_pitaya_rst_seq #(.NCH(NCH), .CW(CW), .ROC_CYC(ROC), .TOC_CYC(TOC_A), .LOCK_FILT(LF))
    dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
  red_pitaya_rst_seq #(.NCH(NCH), .CW(CW), .ROC_CYC(ROC), .TOC_CYC(TOC_B), .LOCK_FILT(LF))
    dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [NCH-1:0] r, input logic g,
                          input logic d, input logic [2:0] s);
    chk({tag, " rst_o"},   32'(r), 32'hF);
    chk({tag, " gts_o"},   32'(g), 32'd1);
    chk({tag, " done_o"},  32'(d), 32'd0);
    chk({tag, " state_o"}, 32'(s), 32'd0);
  endtask

  // Expected outputs after edge e, from the release edges of the current run.
  task automatic chk_model(input string tag, input int e, input int toc,
                           input logic [NCH-1:0] r, input logic g, input logic d,
                           input logic [2:0] s);
    int dn;
    logic [NCH-1:0] er;
    logic [2:0] es;
    dn = fall[NCH-1] + toc;
    for (int i = 0; i < NCH; i++) er[i] = (e < fall[i]);
    if (e < h_edge)             es = 3'd0;
    else if (e < s_edge)        es = 3'd1;
    else if (e < fall[NCH-1])   es = 3'd2;
    else if (e < dn)            es = 3'd3;
    else                        es = 3'd4;
    chk($sformatf("%s e%0d rst_o", tag, e),   32'(r), 32'(er));
    chk($sformatf("%s e%0d gts_o", tag, e),   32'(g), 32'(e < dn));
    chk($sformatf("%s e%0d done_o", tag, e),  32'(d), 32'(e >= dn));
    chk($sformatf("%s e%0d state_o", tag, e), 32'(s), 32'(es));
  endtask

  // One sequence from lock rise (edge 1). akind: 0 none, 1 lock drop after rst_o[0]
  // falls, 2 swrst pulse in DONE, 3 rst_i mid-STAGGER.
  task automatic run_seq(input string tag, input int akind);
    int aedge, last;
    for (int i = 0; i < NCH; i++) dly[i*CW +: CW] = CW'(dv[i]);
    h_edge  = LF;
    s_edge  = h_edge + ROC;
    fall[0] = s_edge + dv[0] + 1;
    for (int i = 1; i < NCH; i++) fall[i] = fall[i-1] + dv[i] + 1;
    last = fall[NCH-1] + TOC_B + 3;
    case (akind)
      1:       aedge = fall[0] + 1;
      2:       aedge = fall[NCH-1] + TOC_B + 2;
      3:       aedge = fall[1];
      default: aedge = -1;
    endcase
    for (int e = 1; e <= last; e++) begin
      lock = 1'b1; swrst = 1'b0; rst = 1'b0;
      if (e == aedge) begin
        if (akind == 1) lock = 1'b0;
        if (akind == 2) swrst = 1'b1;
        if (akind == 3) rst = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (e == aedge) begin
        chk_idle({tag, " abort A"}, ifa.rst_o, ifa.gts_o, ifa.done_o, ifa.state_o);
        chk_idle({tag, " abort B"}, ifb.rst_o, ifb.gts_o, ifb.done_o, ifb.state_o);
        swrst = 1'b0; rst = 1'b0;
        break;
      end
      chk_model({tag, " A"}, e, TOC_A, ifa.rst_o, ifa.gts_o, ifa.done_o, ifa.state_o);
      chk_model({tag, " B"}, e, TOC_B, ifb.rst_o, ifb.gts_o, ifb.done_o, ifb.state_o);
    end
  endtask

  initial begin
    rst = 1'b1; lock = 1'b0; swrst = 1'b0; dly = '0;
    // reset state, with lock wiggling while rst_i is held
    for (int i = 0; i < 4; i++) begin
      lock = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      chk_idle("reset A", ifa.rst_o, ifa.gts_o, ifa.done_o, ifa.state_o);
      chk_idle("reset B", ifb.rst_o, ifb.gts_o, ifb.done_o, ifb.state_o);
    end
    rst = 1'b0; lock = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_idle("nolock A", ifa.rst_o, ifa.gts_o, ifa.done_o, ifa.state_o);

    // zero delays, then software restart from DONE
    for (int i = 0; i < NCH; i++) dv[i] = 0;
    run_seq("t1", 2);

    // mixed delays {ch3=3, ch2=0, ch1=7, ch0=2}
    dv[0] = 2; dv[1] = 7; dv[2] = 0; dv[3] = 3;
    run_seq("t2", 2);

    // short lock pulses never satisfy the filter
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 12; c++) begin
        lock = (c < 10);
        @(posedge clk); @(negedge clk);
        chk_idle($sformatf("lockpulse p%0d c%0d A", p, c), ifa.rst_o, ifa.gts_o, ifa.done_o, ifa.state_o);
        chk_idle($sformatf("lockpulse p%0d c%0d B", p, c), ifb.rst_o, ifb.gts_o, ifb.done_o, ifb.state_o);
      end
    end

    // lock drop just after channel 0 releases, then a clean rerun cut by rst_i mid-STAGGER
    for (int i = 0; i < NCH; i++) dv[i] = 0;
    run_seq("t5", 1);
    run_seq("t6", 3);

    // randomized delays
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NCH; i++) dv[i] = int'($urandom_range(0, 12));
      run_seq($sformatf("rnd%0d", r), (r == 3) ? 0 : 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
